// File: rtl/ysyx_22050019_axi_isram_rd.sv
// rtl/ysyx_22050019_axi_isram_rd.sv - single-outstanding AXI4-Lite read responder over a sync SRAM
// Optional misaligned-fetch SLVERR check: define YSYX_22050019_ISRAM_ALIGN_CHECK_EN.
module ysyx_22050019_axi_isram_rd #(
   parameter logic [63:0] ADDR_BASE = 64'h80000000,
   parameter int          MEM_AW    = 16,
   parameter int          LATENCY   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [63:0]       s_axi_araddr,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [63:0]       s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready,
   output logic              sram_en,
   output logic [MEM_AW-1:0] sram_addr,
   input  logic [63:0]       sram_rdata
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        first_q, first_d;
   logic        dec_q, dec_d;
   logic        slv_q, slv_d;
   logic [63:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;

   logic [64:0] diff;
   logic        in_range;
   logic        misalign;
   logic        unused_bits;

   // Bit 64 is the borrow: set when araddr lies below the window base.
   assign diff        = {1'b0, s_axi_araddr} - {1'b0, ADDR_BASE};
   assign in_range    = !diff[64] && (diff[63:MEM_AW+3] == '0);
   assign sram_addr   = diff[MEM_AW+2:3];
   assign unused_bits = ^diff[2:0];

`ifdef YSYX_22050019_ISRAM_ALIGN_CHECK_EN
   assign misalign = (s_axi_araddr[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         first_q <= 1'b0;
         dec_q   <= 1'b0;
         slv_q   <= 1'b0;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
         dec_q   <= dec_d;
         slv_q   <= slv_d;
         rdata_q <= rdata_d;
         rresp_q <= rresp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      first_d = 1'b0;
      dec_d   = dec_q;
      slv_d   = slv_q;
      rdata_d = rdata_q;
      rresp_d = rresp_q;
      sram_en = 1'b0;
      case (state_q)
         IDLE: begin
            sram_en = s_axi_arvalid && in_range && !misalign;
            if (s_axi_arvalid) begin
               dec_d   = !in_range;
               slv_d   = misalign;
               cnt_d   = 4'(LATENCY);
               first_d = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // SRAM output is only valid in the cycle right after the access edge.
            if (first_q) begin
               if (dec_q) begin
                  rdata_d = '0;
                  rresp_d = RESP_DECERR;
               end else if (slv_q) begin
                  rdata_d = '0;
                  rresp_d = RESP_SLVERR;
               end else begin
                  rdata_d = sram_rdata;
                  rresp_d = RESP_OKAY;
               end
            end
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP: begin
            if (s_axi_rready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign s_axi_arready = (state_q == IDLE);
   assign s_axi_rvalid  = (state_q == RESP);
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_ysyx_22050019_axi_isram_rd.sv
// tb/tb_ysyx_22050019_axi_isram_rd.sv - randomized bench for the instruction SRAM read responder
// Two instances (LATENCY 0 and 3) share clock and reset; each has its own SRAM array.
module tb_ysyx_22050019_axi_isram_rd;

   localparam logic [63:0] BASE  = 64'h80000000;
   localparam int          AW    = 6;
   localparam int          DEPTH = 1 << AW;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [63:0]   araddr     [2];
   logic          arvalid    [2];
   logic          arready    [2];
   logic [63:0]   rdata      [2];
   logic [1:0]    rresp      [2];
   logic          rvalid     [2];
   logic          rready     [2];
   logic          sram_en    [2];
   logic [AW-1:0] sram_addr  [2];
   logic [63:0]   sram_rdata [2];
   logic [63:0]   mem        [2][DEPTH];
   int            en_cnt     [2] = '{0, 0};
   int            en_bad     [2] = '{0, 0};

   int total = 0;
   int bad   = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      ysyx_22050019_axi_isram_rd #(
         .ADDR_BASE(BASE),
         .MEM_AW   (AW),
         .LATENCY  ((g == 0) ? 0 : 3)
      ) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .s_axi_araddr (araddr[g]),
         .s_axi_arvalid(arvalid[g]),
         .s_axi_arready(arready[g]),
         .s_axi_rdata  (rdata[g]),
         .s_axi_rresp  (rresp[g]),
         .s_axi_rvalid (rvalid[g]),
         .s_axi_rready (rready[g]),
         .sram_en      (sram_en[g]),
         .sram_addr    (sram_addr[g]),
         .sram_rdata   (sram_rdata[g])
      );
   end

   // SRAM model: data valid only in the cycle after an enabled edge, garbage otherwise.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (sram_en[i]) begin
            sram_rdata[i] <= mem[i][sram_addr[i]];
            en_cnt[i]     <= en_cnt[i] + 1;
            if (!arready[i]) en_bad[i] <= en_bad[i] + 1;
         end else begin
            sram_rdata[i] <= {$urandom, $urandom};
         end
      end
   end

   function automatic int lat_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic void ref_read(input int d, input logic [63:0] a,
                                    output logic [63:0] data, output logic [1:0] resp);
      if (a < BASE || a >= BASE + 64'(8 * DEPTH)) begin
         data = '0;
         resp = 2'b11;
      end
`ifdef YSYX_22050019_ISRAM_ALIGN_CHECK_EN
      else if (a[1:0] != 2'b00) begin
         data = '0;
         resp = 2'b10;
      end
`endif
      else begin
         data = mem[d][int'((a - BASE) >> 3)];
         resp = 2'b00;
      end
   endfunction

   // Starts and ends at a negedge with the instance idle.
   task automatic do_read(input int d, input logic [63:0] a, input int stall, input bit early);
      logic [63:0] ed;
      logic [1:0]  er;
      int          k;
      int          en0;
      ref_read(d, a, ed, er);
      araddr[d]  = a;
      arvalid[d] = 1'b1;
      rready[d]  = early;
      #1;
      total++;
      if (sram_en[d] !== (er == 2'b00)) begin
         bad++;
         $display("FAIL sram_en_comb d=%0d addr=%h got=%b exp=%b", d, a, sram_en[d], (er == 2'b00));
      end
      if (er == 2'b00) begin
         total++;
         if (sram_addr[d] !== AW'((a - BASE) >> 3)) begin
            bad++;
            $display("FAIL sram_addr d=%0d addr=%h got=%h exp=%h", d, a, sram_addr[d], AW'((a - BASE) >> 3));
         end
      end
      en0 = en_cnt[d];
      @(posedge clk);
      @(negedge clk);
      arvalid[d] = 1'b0;
      araddr[d]  = {$urandom, $urandom};
      total++;
      if (arready[d] !== 1'b0) begin
         bad++;
         $display("FAIL arready_drop d=%0d got=%b exp=0", d, arready[d]);
      end
      k = 0;
      while (rvalid[d] !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      total++;
      if (k != 1 + lat_of(d)) begin
         bad++;
         $display("FAIL latency d=%0d got=%0d exp=%0d", d, k, 1 + lat_of(d));
      end
      for (int s = 0; s <= stall; s++) begin
         total++;
         if (rvalid[d] !== 1'b1 || rdata[d] !== ed || rresp[d] !== er || arready[d] !== 1'b0) begin
            bad++;
            $display("FAIL resp_hold d=%0d addr=%h cyc=%0d got v=%b d=%h r=%b ar=%b exp v=1 d=%h r=%b ar=0",
                     d, a, s, rvalid[d], rdata[d], rresp[d], arready[d], ed, er);
         end
         if (s < stall) @(negedge clk);
      end
      rready[d] = 1'b1;
      @(negedge clk);
      rready[d] = 1'b0;
      total++;
      if (rvalid[d] !== 1'b0 || arready[d] !== 1'b1) begin
         bad++;
         $display("FAIL r_complete d=%0d got v=%b ar=%b exp v=0 ar=1", d, rvalid[d], arready[d]);
      end
      total++;
      if (en_cnt[d] - en0 != ((er == 2'b00) ? 1 : 0)) begin
         bad++;
         $display("FAIL sram_access_count d=%0d addr=%h got=%0d exp=%0d", d, a, en_cnt[d] - en0, (er == 2'b00) ? 1 : 0);
      end
   endtask

   task automatic test_reset();
      #1;
      for (int d = 0; d < 2; d++) begin
         total++;
         if (arready[d] !== 1'b1 || rvalid[d] !== 1'b0 || rdata[d] !== 64'h0 || rresp[d] !== 2'b00) begin
            bad++;
            $display("FAIL reset_state d=%0d got ar=%b v=%b d=%h r=%b exp ar=1 v=0 d=0 r=00",
                     d, arready[d], rvalid[d], rdata[d], rresp[d]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      mem[0][0] = 64'h00000013_00100093;
      do_read(0, BASE, 0, 1'b0);
      do_read(0, BASE + 64'd4, 0, 1'b0);
      do_read(0, BASE + 64'd8 * 64'd9, 0, 1'b1);
   endtask

   task automatic test_stall();
      do_read(1, BASE + 64'd40, 5, 1'b0);
      do_read(1, BASE, 2, 1'b0);
      do_read(0, BASE + 64'd16, 4, 1'b0);
   endtask

   task automatic test_decode_errors();
      for (int d = 0; d < 2; d++) begin
         do_read(d, 64'h7FFFFFF8, 1, 1'b0);
         do_read(d, BASE + 64'(8 * DEPTH), 0, 1'b0);
         do_read(d, BASE + 64'(8 * DEPTH - 8), 0, 1'b0);
         do_read(d, 64'hFFFFFFFF_FFFFFFF8, 0, 1'b1);
      end
   endtask

   task automatic test_alignment();
      do_read(0, BASE + 64'd2, 0, 1'b0);
      do_read(1, BASE + 64'd1, 1, 1'b0);
      do_read(0, BASE + 64'h13, 0, 1'b0);
   endtask

   task automatic test_arvalid_drop();
      int en0;
      en0 = en_cnt[0];
      araddr[0] = BASE;
      #2 arvalid[0] = 1'b1;
      #2 arvalid[0] = 1'b0;
      for (int i = 0; i < 4; i++) @(negedge clk);
      total++;
      if (rvalid[0] !== 1'b0 || arready[0] !== 1'b1 || en_cnt[0] != en0) begin
         bad++;
         $display("FAIL arvalid_drop got v=%b ar=%b accesses=%0d exp v=0 ar=1 accesses=0",
                  rvalid[0], arready[0], en_cnt[0] - en0);
      end
   endtask

   task automatic test_back_to_back(input int d);
      int hs[$];
      int beats;
      int k;
      logic [63:0] ed;
      logic [1:0]  er;
      beats = 0;
      araddr[d] = BASE + 64'd24;
      ref_read(d, araddr[d], ed, er);
      rready[d]  = 1'b1;
      arvalid[d] = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (arvalid[d] && arready[d]) hs.push_back(c);
         if (rvalid[d]) begin
            beats++;
            total++;
            if (rdata[d] !== ed || rresp[d] !== er) begin
               bad++;
               $display("FAIL b2b_data d=%0d got=%h/%b exp=%h/%b", d, rdata[d], rresp[d], ed, er);
            end
         end
         @(negedge clk);
      end
      arvalid[d] = 1'b0;
      k = 0;
      while (!(arready[d] === 1'b1 && rvalid[d] === 1'b0) && k < 40) begin
         @(negedge clk);
         k++;
      end
      rready[d] = 1'b0;
      total++;
      if (k >= 40) begin
         bad++;
         $display("FAIL b2b_drain d=%0d got=timeout exp=idle", d);
      end
      total++;
      if (hs.size() != (29 / (3 + lat_of(d))) + 1 || beats < hs.size() - 1) begin
         bad++;
         $display("FAIL b2b_count d=%0d got hs=%0d beats=%0d exp hs=%0d", d, hs.size(), beats, (29 / (3 + lat_of(d))) + 1);
      end
      for (int i = 1; i < hs.size(); i++) begin
         total++;
         if (hs[i] - hs[i-1] != 3 + lat_of(d)) begin
            bad++;
            $display("FAIL b2b_interval d=%0d got=%0d exp=%0d", d, hs[i] - hs[i-1], 3 + lat_of(d));
         end
      end
   endtask

   task automatic test_random();
      logic [63:0] a;
      int d, sel, stall;
      bit early;
      for (int i = 0; i < 40; i++) begin
         d   = int'($urandom_range(0, 1));
         sel = int'($urandom_range(0, 5));
         case (sel)
            0:       a = BASE + 64'(8 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(0, 7));
            1:       a = BASE + 64'(8 * $urandom_range(0, DEPTH - 1));
            2:       a = BASE - 64'(8 * $urandom_range(1, 4));
            3:       a = BASE + 64'(8 * DEPTH) + 64'($urandom_range(0, 63));
            4:       a = BASE + 64'(8 * (DEPTH - 1)) + 64'($urandom_range(0, 7));
            default: a = {$urandom, $urandom};
         endcase
         early = 1'($urandom_range(0, 1));
         stall = early ? 0 : int'($urandom_range(0, 4));
         do_read(d, a, stall, early);
      end
   endtask

   task automatic test_async_reset();
      int k;
      araddr[1]  = BASE + 64'd32;
      arvalid[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      arvalid[1] = 1'b0;
      k = 0;
      while (rvalid[1] !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (rvalid[1] !== 1'b0 || arready[1] !== 1'b1 || rdata[1] !== 64'h0 || rresp[1] !== 2'b00 || k >= 40) begin
         bad++;
         $display("FAIL async_reset got v=%b ar=%b d=%h r=%b wait=%0d exp v=0 ar=1 d=0 r=00",
                  rvalid[1], arready[1], rdata[1], rresp[1], k);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_read(1, BASE + 64'd48, 0, 1'b0);
      do_read(0, BASE + 64'd56, 1, 1'b0);
   endtask

   task automatic test_sram_en_idle_only();
      for (int d = 0; d < 2; d++) begin
         total++;
         if (en_bad[d] != 0) begin
            bad++;
            $display("FAIL sram_en_outside_idle d=%0d got=%0d exp=0", d, en_bad[d]);
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         araddr[d]  = '0;
         arvalid[d] = 1'b0;
         rready[d]  = 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[d][i] = {$urandom, $urandom};
      end
      test_reset();
      test_basic();
      test_stall();
      test_decode_errors();
      test_alignment();
      test_arvalid_drop();
      test_back_to_back(0);
      test_back_to_back(1);
      test_random();
      test_async_reset();
      test_sram_en_idle_only();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule

// File: doc/ysyx_22050019_axi_isram_rd.md
# ysyx_22050019_axi_isram_rd

Instruction-side AXI4-Lite read responder that serves the fetch unit's single-beat 64-bit reads from a synchronous single-port SRAM. It sits between the IFU read master (AR/R channels) and the instruction SRAM macro. It accepts one outstanding read, inserts a configurable number of wait cycles to stress the master's stall handling, and reports decode errors for addresses outside its window.

## Interface
- `ADDR_BASE`, default 64'h80000000: byte address of SRAM word 0.
- `MEM_AW`, default 16: SRAM word-address width. Depth is 2^MEM_AW 64-bit words.
- `LATENCY`, default 0: extra R-channel wait cycles, 0..15.

- `clk` input 1: clock. Rising edge only.
- `rst_n` input 1: reset. Asynchronous, active-low.
- `s_axi_araddr` input 64: read byte address.
- `s_axi_arvalid` input 1: address valid.
- `s_axi_arready` output 1: address accept.
- `s_axi_rdata` output 64: read doubleword, aligned-down-to-8 address.
- `s_axi_rresp` output 2: 00 OKAY, 10 SLVERR, 11 DECERR.
- `s_axi_rvalid` output 1: read data valid.
- `s_axi_rready` input 1: master accepts data. May be held low arbitrarily, for example by a pipeline stall.
- `sram_en` output 1: SRAM read enable.
- `sram_addr` output MEM_AW: SRAM word index.
- `sram_rdata` input 64: SRAM data, valid in the cycle after the edge that sampled `sram_en`.

## Operation
- States: IDLE, WAIT, RESP. Reset state is IDLE.
- Reset values: `s_axi_arready`=1, `s_axi_rvalid`=0, `s_axi_rdata`=0, `s_axi_rresp`=00, internal counter=0.
- Outputs in IDLE:
  - `s_axi_arready`=1.
  - `sram_en` = `s_axi_arvalid` && in_range && (no alignment error). This is combinational.
  - `sram_addr` = (`s_axi_araddr` − ADDR_BASE)[MEM_AW+2:3].
- in_range means ADDR_BASE ≤ araddr < ADDR_BASE + 8·2^MEM_AW. Compute it with a 64-bit unsigned subtraction and check that borrow=0 and the upper bits are zero.
- AR handshake (`arvalid`&&`arready` at an edge):
  - Latch the error class.
  - Load the counter with LATENCY.
  - Go to WAIT.
  - `arready`=0 until the state returns to IDLE.
- WAIT, first cycle:
  - Capture `sram_rdata` into the data register (OKAY).
  - For an error, load 0 into the data register and set rresp. DECERR takes precedence over SLVERR.
- WAIT exit:
  - If counter==0, go to RESP with `rvalid`=1.
  - Otherwise decrement the counter.
- RESP:
  - `rvalid`, `rdata`, and `rresp` are held stable until `rready`=1 at an edge.
  - On that edge, go to IDLE, `rvalid`=0, `arready`=1.
- `sram_en` is never asserted outside IDLE. `sram_en` is never asserted for an error transaction.
- `arvalid` deasserting while `arready`=1 is legal. No transaction results.
- Asynchronous reset mid-transaction: outputs return to reset values immediately and the pending read is discarded. The first read after reset is a fresh transaction.

## Timing
- AR handshake at edge E0. `rvalid` rises at edge E(1+LATENCY).
- LATENCY=0: `rvalid` is visible in the cycle after E1, so read latency is 2 cycles from handshake to data.
- `arready` rises on the edge that completes the R handshake. The next AR handshake can occur at the following edge at the earliest.
- Minimum issue interval is 3+LATENCY cycles when `rready` is held high.
- `rready` asserted before `rvalid` is legal and has no effect until RESP.

## Configuration
- `YSYX_22050019_ISRAM_ALIGN_CHECK_EN` defined:
  - araddr[1:0]≠00 is a misaligned instruction fetch.
  - It returns SLVERR (10) with `rdata`=0, uses the same latency, and produces no SRAM access.
- Macro undefined:
  - araddr[2:0] is ignored for access.
  - All in-range reads return OKAY.
  - The alignment logic is absent.

## Test plan
- Reset, then araddr=64'h80000000 with arvalid=1, sram word0=64'h00000013_00100093, LATENCY=0 -> arready=0 after E0, rvalid=1 after E1, rdata=64'h00000013_00100093, rresp=00.
- Same address with araddr=64'h80000004 -> identical rdata. sram_addr=0 in both cases.
- LATENCY=3, rready held 0 for 5 cycles after rvalid -> rvalid rises at E4. rdata and rresp are stable for all 5 cycles. The next arready=1 comes only after the rready edge.
- araddr=64'h7FFFFFF8 and araddr=ADDR_BASE+8·2^MEM_AW -> sram_en never asserted, rresp=11, rdata=0.
- With the macro defined, araddr=64'h80000002 -> rresp=10, no sram_en. Without the macro -> rresp=00, word 0 returned.
- Assert rst_n=0 while in RESP with rvalid=1 -> rvalid=0 and arready=1 asynchronously. A read after rst_n rises completes normally.
